// File: rtl/tlb_maint.sv
// rtl/tlb_maint.sv - TLB maintenance engine (TLBWI/TLBWR/TLBR/TLBP) and CP0 Random
module tlb_maint #(
  parameter int TLB_ENTRIES = 16,
  localparam int IW = $clog2(TLB_ENTRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [1:0]    req_op,
  output logic          req_ready,
  input  logic [31:0]   entry_hi,
  input  logic [31:0]   entry_lo0,
  input  logic [31:0]   entry_lo1,
  input  logic [IW-1:0] index,
  input  logic [IW-1:0] wired,
  input  logic          wired_we,
  output logic          tlb_we,
  output logic [IW-1:0] tlb_widx,
  output logic [77:0]   tlb_wdata,
  output logic [IW-1:0] tlb_ridx,
  input  logic [77:0]   tlb_rdata,
  output logic          done,
  output logic [31:0]   rd_hi,
  output logic [31:0]   rd_lo0,
  output logic [31:0]   rd_lo1,
  output logic          probe_miss,
  output logic [IW-1:0] probe_idx,
  output logic [IW-1:0] random
);

  localparam logic [IW-1:0] LAST = IW'(TLB_ENTRIES - 1);
  localparam logic [1:0] OP_TLBWI = 2'd0;
  localparam logic [1:0] OP_TLBWR = 2'd1;
  localparam logic [1:0] OP_TLBR  = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_PROBE, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [18:0]   vpn2_q;
  logic [7:0]    asid_q;
  logic          g_q;
  logic [24:0]   lo0_q, lo1_q;
  logic [IW-1:0] idx_q, scan_q, random_nxt;
  logic          accept, probe_hit, scan_last;
  logic          unused_bits;

  assign unused_bits = ^{entry_hi[12:8], entry_lo0[31:26], entry_lo1[31:26]};

  assign accept    = req_valid && req_ready;
  assign probe_hit = (tlb_rdata[77:59] == vpn2_q) && (tlb_rdata[50] || (tlb_rdata[58:51] == asid_q));
  assign scan_last = (scan_q == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_TLBWI, OP_TLBWR: state_nxt = S_WRITE;
            OP_TLBR:            state_nxt = S_READ;
            default:            state_nxt = S_PROBE;
          endcase
        end
      end
      S_WRITE: state_nxt = S_IDLE;
      S_READ:  state_nxt = S_DONE;
      S_PROBE: if (probe_hit || scan_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes are masked by rst so a reset landing on WRITE drops the write.
  always_comb begin
    req_ready = (state == S_IDLE);
    tlb_we    = (state == S_WRITE) && !rst;
    done      = ((state == S_WRITE) || (state == S_DONE)) && !rst;
    tlb_widx  = idx_q;
    tlb_ridx  = (state == S_PROBE) ? scan_q : idx_q;
    tlb_wdata = {vpn2_q, asid_q, g_q, lo0_q, lo1_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      vpn2_q     <= '0;
      asid_q     <= '0;
      g_q        <= 1'b0;
      lo0_q      <= '0;
      lo1_q      <= '0;
      idx_q      <= '0;
      scan_q     <= '0;
      rd_hi      <= '0;
      rd_lo0     <= '0;
      rd_lo1     <= '0;
      probe_miss <= 1'b0;
      probe_idx  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        vpn2_q <= entry_hi[31:13];
        asid_q <= entry_hi[7:0];
        g_q    <= entry_lo0[0] & entry_lo1[0];
        lo0_q  <= entry_lo0[25:1];
        lo1_q  <= entry_lo1[25:1];
        idx_q  <= (req_op == OP_TLBWR) ? random : index;
        scan_q <= '0;
      end
      if (state == S_READ) begin
        rd_hi  <= {tlb_rdata[77:59], 5'b0, tlb_rdata[58:51]};
        rd_lo0 <= {6'b0, tlb_rdata[49:25], tlb_rdata[50]};
        rd_lo1 <= {6'b0, tlb_rdata[24:0], tlb_rdata[50]};
      end
      if (state == S_PROBE) begin
        if (probe_hit) begin
          probe_miss <= 1'b0;
          probe_idx  <= scan_q;
        end else if (scan_last) begin
          probe_miss <= 1'b1;
          probe_idx  <= '0;
        end else begin
          scan_q <= scan_q + 1'b1;
        end
      end
    end
  end

  // Random reloads when it reaches Wired or zero; a Wired write forces a reload.
  always_comb begin
    random_nxt = random - 1'b1;
    if (wired_we || (random == wired) || (random == '0)) random_nxt = LAST;
  end

  always_ff @(posedge clk) begin
    if (rst) random <= LAST;
    else     random <= random_nxt;
  end

endmodule

// File: tb/tb_tlb_maint.sv
// tb/tb_tlb_maint.sv - self-checking bench for tlb_maint with array model and reference
module tb_tlb_maint;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_op;
  logic        req_ready;
  logic [31:0] entry_hi, entry_lo0, entry_lo1;
  logic [3:0]  index, wired;
  logic        wired_we;
  logic        tlb_we;
  logic [3:0]  tlb_widx, tlb_ridx;
  logic [77:0] tlb_wdata, tlb_rdata;
  logic        done;
  logic [31:0] rd_hi, rd_lo0, rd_lo1;
  logic        probe_miss;
  logic [3:0]  probe_idx, random;

  tlb_maint #(.TLB_ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
    .entry_hi(entry_hi), .entry_lo0(entry_lo0), .entry_lo1(entry_lo1),
    .index(index), .wired(wired), .wired_we(wired_we),
    .tlb_we(tlb_we), .tlb_widx(tlb_widx), .tlb_wdata(tlb_wdata),
    .tlb_ridx(tlb_ridx), .tlb_rdata(tlb_rdata), .done(done),
    .rd_hi(rd_hi), .rd_lo0(rd_lo0), .rd_lo1(rd_lo1),
    .probe_miss(probe_miss), .probe_idx(probe_idx), .random(random)
  );

  always #5 clk = ~clk;

  // The TLB array itself, written only through the engine's write port
  logic [77:0] tlb_mem [16];
  assign tlb_rdata = tlb_mem[tlb_ridx];
  always @(posedge clk) if (tlb_we) tlb_mem[tlb_widx] <= tlb_wdata;

  // Reference: CP0-format copies of every entry, with ignored bits cleared
  logic [31:0] sh_hi [16];
  logic [31:0] sh_lo0 [16];
  logic [31:0] sh_lo1 [16];

  int m_rand;
  always @(posedge clk) begin
    if (rst) m_rand <= 15;
    else if (wired_we || m_rand == int'(wired) || m_rand == 0) m_rand <= 15;
    else m_rand <= m_rand - 1;
  end

  int tests = 0;
  int fails = 0;
  int we_cnt, we_cyc, busy_ok;
  logic [3:0]  widx_seen;
  logic [77:0] wdata_seen;

  task automatic check(input string tag, input logic [77:0] obs, input logic [77:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] hi, input logic [31:0] l0,
                       input logic [31:0] l1, input logic [3:0] idx, output int lat);
    req_op = op; entry_hi = hi; entry_lo0 = l0; entry_lo1 = l1; index = idx; req_valid = 1'b1;
    check("ready_at_issue", req_ready, 1);
    step();
    req_valid = 1'b0; wired_we = 1'b0;
    entry_hi = $urandom; entry_lo0 = $urandom; entry_lo1 = $urandom;
    index = 4'($urandom_range(0, 15)); req_op = 2'($urandom_range(0, 3));
    lat = 0; we_cnt = 0; we_cyc = 0; busy_ok = 1;
    for (int c = 1; c <= 40; c++) begin
      if (tlb_we) begin we_cnt++; we_cyc = c; widx_seen = tlb_widx; wdata_seen = tlb_wdata; end
      if (req_ready) busy_ok = 0;
      if (done) begin lat = c; break; end
      step();
    end
    step();
    check("done_pulse", done, 0);
  endtask

  function automatic logic [31:0] norm_hi(input logic [31:0] hi);
    return hi & 32'hFFFF_E0FF;
  endfunction

  function automatic logic [31:0] norm_lo(input logic [31:0] lo, input logic g);
    return (lo & 32'h03FF_FFFE) | {31'b0, g};
  endfunction

  task automatic wr(input logic use_rand, input logic [31:0] hi, input logic [31:0] l0,
                    input logic [31:0] l1, input logic [3:0] idx);
    int lat;
    logic [3:0] tgt;
    logic g;
    tgt = use_rand ? 4'(m_rand) : idx;
    g = l0[0] & l1[0];
    do_op(use_rand ? 2'd1 : 2'd0, hi, l0, l1, idx, lat);
    check("wr_latency", lat, 1);
    check("wr_we_count", we_cnt, 1);
    check("wr_widx", widx_seen, tgt);
    check("wr_wdata", wdata_seen, {hi[31:13], hi[7:0], g, l0[25:6], l0[5:3], l0[2], l0[1],
                                   l1[25:6], l1[5:3], l1[2], l1[1]});
    sh_hi[tgt] = norm_hi(hi); sh_lo0[tgt] = norm_lo(l0, g); sh_lo1[tgt] = norm_lo(l1, g);
  endtask

  task automatic rd(input logic [3:0] idx);
    int lat;
    do_op(2'd2, $urandom, $urandom, $urandom, idx, lat);
    check("rd_latency", lat, 2);
    check("rd_we_count", we_cnt, 0);
    check("rd_hi", rd_hi, sh_hi[idx]);
    check("rd_lo0", rd_lo0, sh_lo0[idx]);
    check("rd_lo1", rd_lo1, sh_lo1[idx]);
  endtask

  task automatic probe(input logic [31:0] hi);
    int lat, hit;
    hit = -1;
    for (int k = 0; k < 16; k++)
      if (hit < 0 && sh_hi[k][31:13] == hi[31:13] && (sh_lo0[k][0] || sh_hi[k][7:0] == hi[7:0]))
        hit = k;
    do_op(2'd3, hi, $urandom, $urandom, 4'($urandom_range(0, 15)), lat);
    check("probe_latency", lat, (hit < 0) ? 17 : hit + 2);
    check("probe_miss", probe_miss, (hit < 0) ? 1 : 0);
    check("probe_idx", probe_idx, (hit < 0) ? 0 : hit);
    check("probe_busy", busy_ok, 1);
    check("probe_we_count", we_cnt, 0);
  endtask

  initial begin
    int e;
    logic [77:0] old;
    logic [18:0] v;
    logic [31:0] hi, l0, l1;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; entry_hi = '0; entry_lo0 = '0; entry_lo1 = '0;
    index = '0; wired = 4'd3; wired_we = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tlb_mem[k] = '0; sh_hi[k] = '0; sh_lo0[k] = '0; sh_lo1[k] = '0;
    end
    step(); step();
    rst = 1'b0;

    check("rst_ready", req_ready, 1);
    check("rst_we", tlb_we, 0);
    check("rst_done", done, 0);
    check("rst_rd", {rd_hi, rd_lo0, rd_lo1}, 0);
    check("rst_probe", {probe_miss, probe_idx}, 0);
    check("rst_random", random, 15);
    check("rst_idx", {tlb_ridx, tlb_widx}, 0);

    e = 15;
    for (int i = 0; i < 14; i++) begin
      check("random_seq", random, e);
      e = (e == 3) ? 15 : e - 1;
      step();
    end
    for (int i = 0; i < 5; i++) begin
      check("random_seq2", random, e);
      e = e - 1;
      step();
    end
    check("random_at_9", random, 9);
    wired_we = 1'b1;
    step();
    wired_we = 1'b0;
    check("random_wired_we", random, 15);
    wired = 4'd15;
    for (int i = 0; i < 3; i++) begin
      step();
      check("random_wired_max", random, 15);
    end
    wired = 4'd3;

    wr(1'b0, 32'h0040_2011, 32'h0000_1047, 32'h0000_1087, 4'd5);
    check("wi_we_cycle", we_cyc, 1);
    check("wi_g", wdata_seen[50], 1);
    check("wi_vpn2", wdata_seen[77:59], 19'h00201);
    check("wi_asid", wdata_seen[58:51], 8'h11);
    check("wi_pfn0", wdata_seen[49:30], 20'h41);
    check("wi_pfn1", wdata_seen[24:5], 20'h42);
    rd(4'd5);
    check("rd5_hi", rd_hi, 32'h0040_2011);
    check("rd5_lo0", rd_lo0, 32'h0000_1047);
    check("rd5_lo1", rd_lo1, 32'h0000_1087);

    v = 19'h7ABCD;
    wr(1'b0, {v, 5'd0, 8'h22}, 32'h0000_2006, 32'h0000_3006, 4'd3);
    wr(1'b0, {v, 5'd0, 8'h33}, 32'h0000_4007, 32'h0000_5007, 4'd9);
    probe({v, 5'd0, 8'h44});
    check("probe_g_idx", probe_idx, 9);
    probe({v, 5'd0, 8'h22});
    check("probe_asid_idx", probe_idx, 3);
    probe({19'h12345, 5'd0, 8'h22});
    check("probe_nomatch", probe_miss, 1);
    rd(4'd9);
    check("probe_hold", probe_miss, 1);

    for (int c = 0; c < 40 && m_rand != 7; c++) step();
    check("rand_7_before_wr", random, 7);
    wired_we = 1'b1;
    wr(1'b1, 32'h1234_5678, 32'h0ABC_DEF7, 32'h0123_4567, 4'd0);
    check("wr_random_idx", widx_seen, 7);

    old = tlb_mem[12];
    req_op = 2'd0; index = 4'd12; entry_hi = 32'hDEAD_BEEF; entry_lo0 = 32'hFFFF_FFFF;
    entry_lo1 = 32'hFFFF_FFFF; req_valid = 1'b1;
    step();
    req_valid = 1'b0; rst = 1'b1;
    #1;
    check("midrst_we", tlb_we, 0);
    check("midrst_done", done, 0);
    step();
    rst = 1'b0;
    check("midrst_ready", req_ready, 1);
    check("midrst_random", random, 15);
    step();
    check("midrst_we_after", {tlb_we, done}, 0);
    check("midrst_mem", tlb_mem[12], old);

    for (int i = 0; i < 40; i++) begin
      hi = {19'h100 + 19'($urandom_range(0, 3)), 5'($urandom), 8'($urandom_range(0, 3))};
      l0 = $urandom; l1 = $urandom;
      case ($urandom_range(0, 3))
        0: wr(1'b0, hi, l0, l1, 4'($urandom_range(0, 15)));
        1: wr(1'b1, hi, l0, l1, 4'($urandom_range(0, 15)));
        2: rd(4'($urandom_range(0, 15)));
        default: probe(hi);
      endcase
      check("random_model", random, m_rand);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tlb_maint.md
# tlb_maint

TLB maintenance engine: the write/probe side of the TLB that the MMU reads for address translation. It executes the MIPS TLBWI, TLBWR, TLBR and TLBP operations issued by the CP0/execute stage. It drives the TLB array write port and walks the array through a read port. It also owns the CP0 Random register.

## Interface
- `TLB_ENTRIES`, default 16: number of TLB entries, a power of two, ≥4. `IW = log2(TLB_ENTRIES)`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  operation request.
- `req_op`  in  2  operation code: 0 = TLBWI, 1 = TLBWR, 2 = TLBR, 3 = TLBP.
- `req_ready`  out  1  engine idle; the request is accepted when `req_valid && req_ready`.
- `entry_hi`  in  32  CP0 EntryHi: VPN2 is [31:13], ASID is [7:0].
- `entry_lo0`, `entry_lo1`  in  32 each  CP0 EntryLo: PFN [25:6], C [5:3], D [2], V [1], G [0].
- `index`  in  IW  CP0 Index.
- `wired`  in  IW  CP0 Wired.
- `wired_we`  in  1  pulse; CP0 Wired is being written this cycle.
- `tlb_we`  out  1  TLB write strobe.
- `tlb_widx`  out  IW  write index.
- `tlb_wdata`  out  78  entry in packed form. Layout from MSB: {vpn2[18:0], asid[7:0], g, pfn0[19:0], c0[2:0], d0, v0, pfn1[19:0], c1[2:0], d1, v1}. G = entry_lo0.G & entry_lo1.G.
- `tlb_ridx`  out  IW  read index.
- `tlb_rdata`  in  78  entry at `tlb_ridx`, combinational, same cycle.
- `done`  out  1  one-cycle completion pulse.
- `rd_hi`, `rd_lo0`, `rd_lo1`  out  32 each  TLBR result, unpacked to CP0 format. Unused bits are 0. G is replicated into both lo.G fields.
- `probe_miss`  out  1  TLBP result: the Index.P bit.
- `probe_idx`  out  IW  TLBP matching index.
- `random`  out  IW  CP0 Random.

## Operation
- State machine states: IDLE, WRITE, READ, PROBE, DONE. `req_ready = (state == IDLE)`.
- On accept, `entry_hi`, `entry_lo0`, `entry_lo1` and the target index are latched. The target index is `index` for TLBWI and TLBR, and `random` for TLBWR, sampled in the accept cycle. Later input changes are ignored.
- IDLE → WRITE (op 0/1), READ (op 2), PROBE (op 3).
- WRITE:
  - `tlb_we=1`, `tlb_widx` = latched index, `tlb_wdata` = packed latched registers.
  - `done=1` in the same cycle. → IDLE.
- READ:
  - `tlb_ridx` = latched index.
  - `tlb_rdata` is unpacked into the `rd_*` registers. → DONE.
- PROBE:
  - Scan counter k starts at 0; `tlb_ridx = k`.
  - Entry k matches when vpn2 == latched VPN2 and (g or asid == latched ASID).
  - On the first match: `probe_idx = k`, `probe_miss = 0`, → DONE.
  - If k == TLB_ENTRIES-1 without a match: `probe_miss = 1`, `probe_idx = 0`, → DONE.
  - The scan never wraps, and the lowest matching index wins.
- DONE: `done=1`. → IDLE.
- Random:
  - Decrements every cycle.
  - When `random == wired`, or `random == 0`, the next value is TLB_ENTRIES-1.
  - `wired_we` forces the next value to TLB_ENTRIES-1; it has priority over the decrement.
  - If `wired == TLB_ENTRIES-1`, Random stays at TLB_ENTRIES-1.
- Only one operation is in flight. `req_valid` while busy is held off by `req_ready=0`.

## Timing
- Reset values:
  - state = IDLE, so `req_ready=1` from the first cycle after reset.
  - `tlb_we=0`, `done=0`.
  - `rd_*` = 0, `probe_miss=0`, `probe_idx=0`.
  - `random` = TLB_ENTRIES-1.
  - `tlb_ridx=0`, `tlb_widx=0`.
- Latency, with the request accepted at cycle T:
  - TLBWI/TLBWR: `tlb_we` and `done` at T+1.
  - TLBR: read at T+1; `rd_*` valid and `done` at T+2.
  - TLBP: entry k is compared at T+1+k.
    - A hit at k gives `done` at T+2+k.
    - A miss gives `done` at T+1+TLB_ENTRIES.
- Result outputs hold their values until the next operation of the same kind completes.
- `tlb_we` is strictly a one-cycle pulse and is never asserted outside WRITE.
- Back-to-back: a new request can be accepted in the cycle after `done`.
- Reset mid-operation: the engine returns to IDLE next cycle, with no write and no `done`. A pending WRITE is dropped.

## Test plan
- After reset, `random` reads 15, then 14, 13 … down to `wired`=3, then back to 15. Assert `wired_we` at random=9; the next value must be 15.
- TLBWI with index=5, entry_hi=0x0040_2011, entry_lo0=0x0000_1047, entry_lo1=0x0000_1087 (both G=1).
  - Required: `tlb_we` exactly at T+1, `tlb_widx=5`, g=1, vpn2=0x00201, asid=0x11, pfn0=0x41, pfn1=0x42.
- TLBR of index 5 on a model array holding that entry.
  - Required: `done` at T+2, `rd_hi=0x0040_2011`, `rd_lo0=0x0000_1047`, `rd_lo1=0x0000_1087`.
- TLBP with VPN2 present at entries 3 and 9, ASID differing, G=1 at entry 9 only.
  - Required: `probe_idx=9`, `probe_miss=0`, `done` at T+11.
  - Repeat with matching ASID: `probe_idx=3`, `done` at T+5.
- TLBP with no match.
  - Required: `probe_miss=1`, `done` at T+17, and `req_ready=0` for T+1..T+17.
- TLBWR accepted while random=7, with `wired_we` in the same cycle.
  - Required: write to index 7.
  - Also: assert `rst` at T+1 of a TLBWI; no `tlb_we` occurs.
